// File: rtl/seq_cu_pkg.sv
// Shared definitions for the fill/copy sequencer: the 2-bit state
// encoding (which doubles as the externally visible phase) and the
// strobe patterns driven in each active phase.
package seq_cu_pkg;

   // State encoding is also the phase output, so the values are fixed.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      FILL = 2'b01,
      COPY = 2'b10,
      DONE = 2'b11
   } state_t;

   // Strobe bundle, ordered WEA, IncA, IncB, WEB from MSB to LSB.
   typedef struct packed {
      logic wea;
      logic incA;
      logic incB;
      logic web;
   } strobe_t;

   localparam strobe_t STROBE_NONE = 4'b0000;
   localparam strobe_t STROBE_FILL = 4'b1100;
   localparam strobe_t STROBE_COPY = 4'b0111;

   // Maps a state onto its unstalled strobe pattern; IDLE and DONE are quiet.
   function automatic strobe_t decodeStrobes(input state_t s);
      strobe_t r;
      r = STROBE_NONE;
      if (s == FILL) r = STROBE_FILL;
      if (s == COPY) r = STROBE_COPY;
      return r;
   endfunction

endpackage

// File: rtl/seq_cu_if.sv
// Control/status bundle between a requester and the fill/copy sequencer.
// The requester (master) drives start/stall/cont; the sequencer (slave)
// drives the memory strobes and the status signals.
interface seq_cu_if #(
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH);

   logic          start;
   logic          stall;
   logic          cont;
   logic          WEA;
   logic          IncA;
   logic          IncB;
   logic          WEB;
   logic          busy;
   logic          done;
   logic [1:0]    phase;
   logic [CW-1:0] count;

   modport master (
      output start, stall, cont,
      input  WEA, IncA, IncB, WEB, busy, done, phase, count
   );

   modport slave (
      input  start, stall, cont,
      output WEA, IncA, IncB, WEB, busy, done, phase, count
   );

endinterface

// File: rtl/seq_cnt.sv
// Phase position counter. Counts up while enabled and wraps explicitly
// to zero after the terminal value, so a non-power-of-two phase length
// never exposes out-of-range values. Clear wins over enable.
module seq_cnt #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] last_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             tc_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Next count: hold, clear, step, or wrap from the terminal value back to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tc_o ? '0 : cnt_q + 1'b1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == last_i);

endmodule

// File: rtl/seq_cu.sv
// Fill/copy sequencer. One start request runs DEPTH cycles of FILL
// (write memory A) followed by DEPTH cycles of COPY (read A, write B),
// then a single DONE cycle. With cont set, DONE loops straight back
// into FILL. Stall freezes the sequence and gates the strobes off
// combinationally so the external address counters stay aligned.
module seq_cu
   import seq_cu_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic     clk,
   input  logic     rst,
   seq_cu_if.slave  bus
);

   localparam int            CW   = $clog2(DEPTH);
   localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

   state_t        state_q;
   state_t        state_d;
   strobe_t       strb;
   logic          cntEn;
   logic          cntClr;
   logic          cntTc;
   logic [CW-1:0] cnt;

   // Position within the current phase; only advances while an active phase is not stalled.
   seq_cnt #(
      .WIDTH (CW)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (cntClr),
      .en_i   (cntEn),
      .last_i (LAST),
      .cnt_o  (cnt),
      .tc_o   (cntTc)
   );

   // State register; reset abandons any partial sequence without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: start only matters in IDLE, cont only in DONE, stall only in FILL/COPY.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (bus.start) state_d = FILL;
         FILL: if (!bus.stall && cntTc) state_d = COPY;
         COPY: if (!bus.stall && cntTc) state_d = DONE;
         DONE: state_d = bus.cont ? FILL : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode: strobes follow state gated by stall, plus status and counter control.
   always_comb begin
      strb   = decodeStrobes(state_q);
      cntEn  = 1'b0;
      cntClr = 1'b0;
      if (bus.stall) begin
         strb = STROBE_NONE;
      end
      if ((state_q == FILL) || (state_q == COPY)) begin
         cntEn = !bus.stall;
      end else begin
         cntClr = 1'b1;
      end
      bus.WEA   = strb.wea;
      bus.IncA  = strb.incA;
      bus.IncB  = strb.incB;
      bus.WEB   = strb.web;
      bus.busy  = (state_q == FILL) || (state_q == COPY);
      bus.done  = (state_q == DONE);
      bus.phase = state_q;
      bus.count = cnt;
   end

endmodule

// File: tb/tb_seq_cu.sv
// Directed bench for the fill/copy sequencer. Three instances (DEPTH 8,
// 2 and 5) share one set of stimulus; each scenario checks the instance
// it targets cycle by cycle against hand-derived expectations.
module tb_seq_cu;

   logic clk;
   logic rst;
   logic start;
   logic stall;
   logic cont;

   int checks;
   int failures;
   int weaCnt;
   int webCnt;
   int incACnt;

   localparam logic [3:0] S_NONE = 4'b0000;
   localparam logic [3:0] S_FILL = 4'b1100;
   localparam logic [3:0] S_COPY = 4'b0111;
   localparam logic [1:0] P_IDLE = 2'b00;
   localparam logic [1:0] P_FILL = 2'b01;
   localparam logic [1:0] P_COPY = 2'b10;
   localparam logic [1:0] P_DONE = 2'b11;

   seq_cu_if #(.DEPTH(8)) if8 ();
   seq_cu_if #(.DEPTH(2)) if2 ();
   seq_cu_if #(.DEPTH(5)) if5 ();

   assign if8.start = start;
   assign if8.stall = stall;
   assign if8.cont  = cont;
   assign if2.start = start;
   assign if2.stall = stall;
   assign if2.cont  = cont;
   assign if5.start = start;
   assign if5.stall = stall;
   assign if5.cont  = cont;

   seq_cu #(.DEPTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
   seq_cu #(.DEPTH(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
   seq_cu #(.DEPTH(5)) dut5 (.clk(clk), .rst(rst), .bus(if5.slave));

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] pack(input logic [3:0] s, input logic b, input logic d,
                                        input logic [1:0] ph, input int c);
      logic [7:0] c8;
      c8 = c[7:0];
      return {s, b, d, ph, c8};
   endfunction

   function automatic logic [15:0] obs8();
      return {if8.WEA, if8.IncA, if8.IncB, if8.WEB, if8.busy, if8.done, if8.phase, 5'b0, if8.count};
   endfunction

   function automatic logic [15:0] obs2();
      return {if2.WEA, if2.IncA, if2.IncB, if2.WEB, if2.busy, if2.done, if2.phase, 7'b0, if2.count};
   endfunction

   function automatic logic [15:0] obs5();
      return {if5.WEA, if5.IncA, if5.IncB, if5.WEB, if5.busy, if5.done, if5.phase, 5'b0, if5.count};
   endfunction

   // Expected output of an unstalled DEPTH=8 run at cycle c (1 = first FILL cycle).
   function automatic logic [15:0] runExp8(input int c);
      if (c <= 8)  return pack(S_FILL, 1'b1, 1'b0, P_FILL, c - 1);
      if (c <= 16) return pack(S_COPY, 1'b1, 1'b0, P_COPY, c - 9);
      if (c == 17) return pack(S_NONE, 1'b0, 1'b1, P_DONE, 0);
      return pack(S_NONE, 1'b0, 1'b0, P_IDLE, 0);
   endfunction

   task automatic applyStimulus(input logic r, input logic s, input logic sl, input logic co);
      rst   = r;
      start = s;
      stall = sl;
      cont  = co;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      logic [15:0] expv;
      checks   = 0;
      failures = 0;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

      // Reset held two edges with start high: reset must win.
      nextCycle();
      nextCycle();
      #1;
      checkOutput("reset", obs8(), pack(S_NONE, 1'b0, 1'b0, P_IDLE, 0));

      // Single run without stall.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 18; c++) begin
         nextCycle();
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
         #1;
         checkOutput($sformatf("run c%0d", c), obs8(), runExp8(c));
      end

      // Stall for three cycles at FILL count 3.
      weaCnt  = 0;
      webCnt  = 0;
      incACnt = 0;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 21; c++) begin
         nextCycle();
         applyStimulus(1'b0, 1'b0, (c >= 4) && (c <= 6), 1'b0);
         #1;
         if (c <= 3)       expv = pack(S_FILL, 1'b1, 1'b0, P_FILL, c - 1);
         else if (c <= 6)  expv = pack(S_NONE, 1'b1, 1'b0, P_FILL, 3);
         else if (c <= 11) expv = pack(S_FILL, 1'b1, 1'b0, P_FILL, c - 4);
         else if (c <= 19) expv = pack(S_COPY, 1'b1, 1'b0, P_COPY, c - 12);
         else if (c == 20) expv = pack(S_NONE, 1'b0, 1'b1, P_DONE, 0);
         else              expv = pack(S_NONE, 1'b0, 1'b0, P_IDLE, 0);
         checkOutput($sformatf("stall c%0d", c), obs8(), expv);
         weaCnt  += int'(if8.WEA);
         webCnt  += int'(if8.WEB);
         incACnt += int'(if8.IncA);
      end
      checkOutput("stall WEA total", 16'(weaCnt), 16'd8);
      checkOutput("stall WEB total", 16'(webCnt), 16'd8);
      checkOutput("stall IncA total", 16'(incACnt), 16'd16);

      // Continuous mode for three sequences, cont dropped mid third run.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      for (int c = 1; c <= 52; c++) begin
         int p;
         nextCycle();
         applyStimulus(1'b0, 1'b0, 1'b0, c < 40);
         #1;
         p = (c - 1) % 17 + 1;
         if (c == 52)      expv = pack(S_NONE, 1'b0, 1'b0, P_IDLE, 0);
         else if (p == 17) expv = pack(S_NONE, 1'b0, 1'b1, P_DONE, 0);
         else if (p <= 8)  expv = pack(S_FILL, 1'b1, 1'b0, P_FILL, p - 1);
         else              expv = pack(S_COPY, 1'b1, 1'b0, P_COPY, p - 9);
         checkOutput($sformatf("cont c%0d", c), obs8(), expv);
      end

      // Start held during busy is ignored; reset at COPY count 5 aborts silently.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 14; c++) begin
         nextCycle();
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
         #1;
         checkOutput($sformatf("busystart c%0d", c), obs8(), runExp8(c));
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("abort reset", obs8(), pack(S_NONE, 1'b0, 1'b0, P_IDLE, 0));
      for (int c = 1; c <= 3; c++) begin
         nextCycle();
         #1;
         checkOutput($sformatf("abort idle c%0d", c), obs8(), pack(S_NONE, 1'b0, 1'b0, P_IDLE, 0));
      end

      // Small and non-power-of-two depths run from one shared start pulse.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 12; c++) begin
         nextCycle();
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
         #1;
         if (c <= 6) begin
            if (c <= 2)      expv = pack(S_FILL, 1'b1, 1'b0, P_FILL, c - 1);
            else if (c <= 4) expv = pack(S_COPY, 1'b1, 1'b0, P_COPY, c - 3);
            else if (c == 5) expv = pack(S_NONE, 1'b0, 1'b1, P_DONE, 0);
            else             expv = pack(S_NONE, 1'b0, 1'b0, P_IDLE, 0);
            checkOutput($sformatf("depth2 c%0d", c), obs2(), expv);
         end
         if (c <= 5)       expv = pack(S_FILL, 1'b1, 1'b0, P_FILL, c - 1);
         else if (c <= 10) expv = pack(S_COPY, 1'b1, 1'b0, P_COPY, c - 6);
         else if (c == 11) expv = pack(S_NONE, 1'b0, 1'b1, P_DONE, 0);
         else              expv = pack(S_NONE, 1'b0, 1'b0, P_IDLE, 0);
         checkOutput($sformatf("depth5 c%0d", c), obs5(), expv);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
